// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
// The three-state controller encoding is used by the top-level FSM.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell. The sequencer time-shares this cell across all
// operand bits.
module full_adder (
  input  logic Cin,
  input  logic A,
  input  logic B,
  output logic sum,
  output logic Cout
);

  assign sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full adder cell, LSB first, over WIDTH cycles.
// Start/done handshake; the result is held until the next accepted start.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             ovf
);

  state_t             state_reg;
  state_t             state_next;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               c_msb_in;
  logic               fa_sum;
  logic               fa_cout;
  logic               last_bit;
  logic               msb_m1_bit;

  full_adder u_fa (
    .Cin  (carry),
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .sum  (fa_sum),
    .Cout (fa_cout)
  );

  assign last_bit   = (cnt == CNT_W'(WIDTH - 1));
  assign msb_m1_bit = (cnt == CNT_W'(WIDTH - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      c_msb_in  <= 1'b0;
      sum       <= '0;
      Cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1, so the forced carry-in replaces Cin.
            a_sh  <= A;
            b_sh  <= op_sub ? ~B : B;
            carry <= op_sub ? 1'b1 : Cin;
            cnt   <= '0;
            sum   <= '0;
          end
        end
        S_RUN: begin
          sum   <= {fa_sum, sum[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          // Carry into the MSB is kept so signed overflow can be formed at the end.
          if (msb_m1_bit) begin
            c_msb_in <= fa_cout;
          end
          if (last_bit) begin
            Cout <= fa_cout;
            ovf  <= c_msb_in ^ fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last_bit) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state_reg == S_RUN) || (state_reg == S_DONE);
  assign done = (state_reg == S_DONE);

endmodule
